// File: rtl/spm_sched_pkg.sv
// spm_sched_pkg: shared types and sizing helpers for the multiplier job scheduler.
package spm_sched_pkg;
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
   localparam int SPM_W = 32;
   function automatic int cnt_w(input int w);
      return $clog2(2 * w + 1);
   endfunction
endpackage

// File: rtl/spm_serial_core.sv
// spm_serial_core: carry-save serial-parallel multiplier, y enters LSB first, one product bit out per cycle.
module spm_serial_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [W-1:0] x,
   input  logic         y,
   output logic         p
);
   logic [W-1:0] s, c, fs, fc;
   for (genvar g = 0; g < W; g++) begin : g_cell
      assign {fc[g], fs[g]} = {1'b0, s[g]} + {1'b0, c[g]} + {1'b0, x[g] & y};
   end
   // sums shift down one weight per cycle; carries already carry weight i+1, so they stay in place
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= '0;
         c <= '0;
         p <= 1'b0;
      end else if (clr) begin
         s <= '0;
         c <= '0;
         p <= 1'b0;
      end else begin
         s <= {1'b0, fs[W-1:1]};
         c <= fc;
         p <= fs[0];
      end
   end
endmodule

// File: rtl/spm_job_scheduler.sv
// spm_job_scheduler: round-robin sharing of one serial multiplier core among NREQ requesters.
// Define SPM_SCHED_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module spm_job_scheduler
   import spm_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W = SPM_W,
   parameter int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_x,
   input  logic [NREQ*W-1:0] req_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [2*W-1:0]    rsp_p,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy
);
   localparam int CW = cnt_w(W);
   state_t state;
   logic [IDW-1:0] rr, gnt, idx;
   logic found, accept, p;
   logic [W-1:0] xbuf, ybuf, sel_x, sel_y;
   logic [2*W-2:0] acc;
   logic [2*W-1:0] acc_nx;
   logic [CW-1:0] cnt;
`ifdef SPM_SCHED_SIGNED_EN
   logic neg;
`endif
   // scan downwards so the nearest requester after rr is the last one written
   always_comb begin
      gnt = '0;
      idx = '0;
      found = 1'b0;
      sel_x = '0;
      sel_y = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(rr) + k) % NREQ);
         if (req_valid[idx]) begin
            gnt = idx;
            found = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         sel_x = (gnt == IDW'(i)) ? req_x[i*W +: W] : sel_x;
         sel_y = (gnt == IDW'(i)) ? req_y[i*W +: W] : sel_y;
      end
      req_ready = (state == IDLE && found && !rst) ? NREQ'(1) << gnt : '0;
   end
   assign accept = |(req_valid & req_ready);
   assign acc_nx = {p, acc};
   assign busy = state != IDLE;
   spm_serial_core #(.W(W)) u_core (
      .clk(clk),
      .rst(rst),
      .clr(accept),
      .x(xbuf),
      .y(state == MUL && ybuf[0]),
      .p(p)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         rr <= IDW'(NREQ - 1);
         xbuf <= '0;
         ybuf <= '0;
         acc <= '0;
         cnt <= '0;
         rsp_valid <= 1'b0;
         rsp_p <= '0;
         rsp_id <= '0;
`ifdef SPM_SCHED_SIGNED_EN
         neg <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (accept) begin
               state <= MUL;
               rr <= gnt;
               rsp_id <= gnt;
               cnt <= '0;
               acc <= '0;
`ifdef SPM_SCHED_SIGNED_EN
               xbuf <= sel_x[W-1] ? -sel_x : sel_x;
               ybuf <= sel_y[W-1] ? -sel_y : sel_y;
               neg <= sel_x[W-1] ^ sel_y[W-1];
`else
               xbuf <= sel_x;
               ybuf <= sel_y;
`endif
            end
            MUL: begin
               ybuf <= ybuf >> 1;
               cnt <= cnt + 1'b1;
               if (cnt != '0) acc <= acc_nx[2*W-1:1];
               if (cnt == CW'(2 * W)) begin
                  state <= RESP;
                  rsp_valid <= 1'b1;
`ifdef SPM_SCHED_SIGNED_EN
                  rsp_p <= neg ? -acc_nx : acc_nx;
`else
                  rsp_p <= acc_nx;
`endif
               end
            end
            RESP: if (rsp_ready) begin
               state <= IDLE;
               rsp_valid <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spm_job_scheduler.sv
// tb_spm_job_scheduler: vector table plus scoreboard checks of the shared multiplier scheduler.
module tb_spm_job_scheduler;
   localparam int NREQ = 4;
   localparam int W = 32;
   localparam int IDW = 2;
   logic clk, rst, rsp_valid, rsp_ready, busy;
   logic [NREQ-1:0] req_valid, req_ready;
   logic [NREQ*W-1:0] req_x, req_y;
   logic [2*W-1:0] rsp_p;
   logic [IDW-1:0] rsp_id;
   typedef struct {
      logic [IDW-1:0] id;
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [2*W-1:0] p;
   } vec_t;
   vec_t sb[$];
   vec_t tbl[8];
   vec_t e;
   logic [IDW-1:0] acc_order[$];
   int n_cmp, n_bad, r2_ready;
   logic [2*W-1:0] got_p;
   logic [IDW-1:0] got_id;
   int lat;

   spm_job_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_p(rsp_p), .rsp_id(rsp_id), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SPM_SCHED_SIGNED_EN
      return 64'($signed(x)) * 64'($signed(y));
`else
      return 64'(x) * 64'(y);
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // accepts push the model result, response handshakes pop and compare
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back('{IDW'(i), req_x[i*W +: W], req_y[i*W +: W], model(req_x[i*W +: W], req_y[i*W +: W])});
               acc_order.push_back(IDW'(i));
            end
         end
         if (req_ready[2]) r2_ready++;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got response id %0d p %h, required none", rsp_id, rsp_p);
            end else begin
               e = sb.pop_front();
               check("sb_p", rsp_p, e.p);
               check("sb_id", 64'(rsp_id), 64'(e.id));
            end
         end
      end
   end

   task automatic run_job(input int id, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [2*W-1:0] p, output logic [IDW-1:0] rid, output int n_lat);
      int n = 0;
      req_x[id*W +: W] = x;
      req_y[id*W +: W] = y;
      req_valid[id] = 1'b1;
      #1;
      while (!req_ready[id] && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("grant", 64'(req_ready[id]), 64'd1);
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      n_lat = 0;
      while (!rsp_valid && n_lat < 300) begin
         @(posedge clk);
         #1;
         n_lat++;
      end
      p = rsp_p;
      rid = rsp_id;
      if (rsp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_sb", 64'(sb.size()), 64'd0);
      check("drain_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      r2_ready = 0;
      rst = 1'b0;
      req_valid = '0;
      req_x = '0;
      req_y = '0;
      rsp_ready = 1'b1;
      tbl[0] = '{2'd0, 32'd7, 32'd6, 64'd42};
      tbl[1] = '{2'd1, 32'd0, 32'hFFFFFFFF, 64'd0};
      tbl[2] = '{2'd3, 32'h10000, 32'h10000, 64'h1_0000_0000};
      tbl[3] = '{2'd2, 32'd12345, 32'd67890, 64'd838102050};
      tbl[4] = '{2'd1, 32'h7FFFFFFF, 32'd2, 64'hFFFFFFFE};
      for (int i = 5; i < 8; i++) begin
         tbl[i].id = IDW'(i % NREQ);
         tbl[i].x = $urandom;
         tbl[i].y = $urandom;
         tbl[i].p = model(tbl[i].x, tbl[i].y);
      end
      #2 rst = 1'b1;
      req_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_p", rsp_p, 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      req_valid = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      run_job(2, 32'd3, 32'd5, got_p, got_id, lat);
      check("lat", 64'(lat), 64'd65);
      check("single_p", got_p, 64'd15);
      check("single_id", 64'(got_id), 64'd2);
      run_job(1, 32'hFFFFFFFF, 32'hFFFFFFFF, got_p, got_id, lat);
`ifdef SPM_SCHED_SIGNED_EN
      check("max_p", got_p, 64'd1);
`else
      check("max_p", got_p, 64'hFFFFFFFE00000001);
`endif
      run_job(0, 32'd1, 32'd1, got_p, got_id, lat);
      check("after_max_p", got_p, 64'd1);

      for (int i = 0; i < 8; i++) begin
         run_job(int'(tbl[i].id), tbl[i].x, tbl[i].y, got_p, got_id, lat);
         check($sformatf("tbl_p[%0d]", i), got_p, tbl[i].p);
         check($sformatf("tbl_id[%0d]", i), 64'(got_id), 64'(tbl[i].id));
      end

      rsp_ready = 1'b0;
      run_job(3, 32'd9, 32'd11, got_p, got_id, lat);
      check("bp_lat", 64'(lat), 64'd65);
      req_x[0 +: W] = 32'd4;
      req_y[0 +: W] = 32'd5;
      req_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_p", rsp_p, 64'd99);
         check("bp_id", 64'(rsp_id), 64'd3);
         check("bp_ready", 64'(req_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_regrant", 64'(req_ready), 64'b0001);
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      drain();

      run_job(1, 32'd6, 32'd7, got_p, got_id, lat);
      check("pre_rst_p", got_p, 64'd42);
      req_x[W +: W] = 32'hDEADBEEF;
      req_y[W +: W] = 32'h12345;
      req_valid[1] = 1'b1;
      #1;
      check("mid_grant", 64'(req_ready), 64'b0010);
      @(posedge clk);
      #1 req_valid[1] = 1'b0;
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd0);
      check("mid_rst_p", rsp_p, 64'd0);
      sb.delete();
      acc_order.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         req_x[i*W +: W] = W'(i + 2);
         req_y[i*W +: W] = W'(100 + i);
      end
      req_valid = 4'b1011;
      r2_ready = 0;
      #1;
      check("rr_after_reset", 64'(req_ready), 64'b0001);
      for (int n = 0; n < 800 && acc_order.size() < 6; n++) begin
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      check("rr_count", 64'(acc_order.size()), 64'd6);
      for (int i = 0; i < 6 && i < acc_order.size(); i++)
         check($sformatf("rr_order[%0d]", i), 64'(acc_order[i]), (i % 3 == 2) ? 64'd3 : 64'(i % 3));
      check("rr_req2_ready", 64'(r2_ready), 64'd0);
      drain();

`ifdef SPM_SCHED_SIGNED_EN
      run_job(0, -32'sd2, 32'd3, got_p, got_id, lat);
      check("sgn_neg", got_p, 64'hFFFFFFFFFFFFFFFA);
      run_job(2, 32'h80000000, 32'h80000000, got_p, got_id, lat);
      check("sgn_min", got_p, 64'h4000000000000000);
      drain();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/spm_job_scheduler.md
# spm_job_scheduler

Shares one serial-parallel multiplier core between NREQ independent requesters on the user-project side of the SoC. Requesters submit W×W operand pairs over a valid/ready channel. A round-robin arbiter picks one job at a time, and the block sequences the core for a fixed number of bit-serial cycles. It then returns the 2W-bit product, tagged with the requester index, on a single response channel.

## Interface
- NREQ, 4: number of requesters, 2..8
- W, 32: operand width; product width is 2W
- IDW, $clog2(NREQ): requester tag width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  per-requester job valid
- req_ready  out  NREQ  per-requester accept; reset 0
- req_x  in  NREQ*W  multiplicands, requester i at [i*W +: W]
- req_y  in  NREQ*W  multipliers, same packing
- rsp_valid  out  1  product available; reset 0
- rsp_ready  in  1  consumer accepts product
- rsp_p  out  2W  product; reset 0
- rsp_id  out  IDW  index of the requester that owns rsp_p; reset 0
- busy  out  1  high in any state other than IDLE; reset 0

## Operation
- States:
  - IDLE → MUL on an accept.
  - MUL → RESP when cnt==2W.
  - RESP → IDLE on rsp_valid&rsp_ready.
- Arbitration:
  - Round-robin. Pointer rr holds the last granted index; reset value is NREQ-1, so requester 0 has first priority.
  - Search order is rr+1 .. rr+NREQ, mod NREQ.
  - req_ready[i] is high only in IDLE, for the single granted i, and is combinational from req_valid.
  - Accept = req_valid[i]&req_ready[i]. rr updates only on accept.
- On the accept edge:
  - Latch x into xbuf and y into ybuf; rsp_id <= i; cnt <= 0.
  - Clear the core and acc (2W-bit product shift register).
- MUL, each cycle:
  - Feed ybuf[0] to the core; ybuf shifts right with zero fill. After W shifts the core sees 0.
  - When cnt>=1: acc <= {p, acc[2W-1:1]}.
  - cnt increments.
  - The core's p is registered, so bit k of the product appears when cnt=k+1. acc captures exactly 2W bits over cnt=1..2W.
- Leaving MUL (cnt==2W): rsp_p <= final acc, including the bit captured on that edge.
- RESP:
  - rsp_p and rsp_id are held stable while rsp_valid&!rsp_ready.
  - No new accept until IDLE.
- Arithmetic is unsigned by default; the result is exact in 2W bits with no overflow.
- Reset at any time: all state returns to IDLE, the in-flight job is dropped, and no response is issued.
- A requester that deasserts req_valid before its accept loses nothing. A grant is not sticky.

## Timing
- Accept edge E0. rsp_valid rises after edge E0+2W+1, i.e. E65 for W=32.
- Minimum accept-to-accept spacing, with rsp_ready tied high: 2W+3 cycles (67 for W=32).
- The core clear is synchronous and asserted only on the accept edge. The core runs nowhere else outside MUL.

## Configuration
- SPM_SCHED_SIGNED_EN defined: operands are two's complement.
  - On accept, xbuf and ybuf receive |x| and |y|, with -2^(W-1) mapping to the unsigned value 2^(W-1).
  - neg <= x[W-1]^y[W-1].
  - On the MUL→RESP edge, rsp_p <= neg ? -acc : acc, with no extra cycle.
- Undefined: unsigned operands; no sign logic is synthesized.

## Structure
- Package spm_sched_pkg:
  - state enum {IDLE, MUL, RESP}
  - default W
  - cnt width function $clog2(2W+1)
- Sub-module spm_serial_core:
  - Ports: clk, rst, clr, x[W], y (1 bit), p.
  - A carry-save chain of W registered sum/carry cells with synchronous clr.
  - It is separate so that carry state is provably flushed between jobs.
- Arbiter, counter and FSM live in spm_job_scheduler.

## Test plan
- Single job, unsigned: requester 2 submits x=3, y=5 → rsp_p=15 and rsp_id=2. rsp_valid rises exactly 65 edges after accept.
- Max operands, unsigned: x=y=0xFFFFFFFF → rsp_p=0xFFFFFFFE00000001. A following job x=1, y=1 returns 1, proving the core was cleared.
- Round-robin fairness: requesters 0,1,3 hold valid continuously → accepted in order 0,1,3,0,1,3. Requester 2 never gets req_ready.
- Backpressure: rsp_ready held low 10 cycles in RESP → rsp_valid, rsp_p and rsp_id are stable throughout; all req_ready stay 0 until the handshake.
- Reset mid-MUL: assert rst at cnt=30 → busy, rsp_valid, req_ready and rsp_p go to 0 immediately. After release, requester 0 is granted first.
- Signed, with SPM_SCHED_SIGNED_EN:
  - x=-2, y=3 → 0xFFFFFFFFFFFFFFFA.
  - x=y=0x80000000 → 0x4000000000000000.
